// File: rtl/alu_pkg.sv
// Shared opcode definitions for the registered ALU.
package alu_pkg;

    localparam int unsigned SEL_W = 2;

    typedef enum logic [SEL_W-1:0] {
        ALU_AND  = 2'b00,
        ALU_OR   = 2'b01,
        ALU_ADD  = 2'b10,
        ALU_NAND = 2'b11
    } alu_op_e;

endpackage

// File: rtl/alu_ripple_adder.sv
// Ripple-carry adder built from a chained full-adder array, carry-in tied low.
module alu_ripple_adder #(
    parameter int unsigned width = 4
) (
    input  logic [width-1:0] a,
    input  logic [width-1:0] b,
    output logic [width-1:0] sum,
    output logic             cout
);

    logic [width:0] c;

    assign c[0] = 1'b0;

    // One full adder per bit; carry ripples from LSB to MSB.
    for (genvar i = 0; i < width; i++) begin : g_fa
        assign sum[i]  = a[i] ^ b[i] ^ c[i];
        assign c[i+1]  = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign cout = c[width];

endmodule

// File: rtl/alu_4bit.sv
// Registered ALU: AND / OR / ADD / NAND with carry-out, one-cycle latency.
module alu_4bit
    import alu_pkg::*;
#(
    parameter int unsigned width = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [width-1:0] a,
    input  logic [width-1:0] b,
    input  logic [SEL_W-1:0] sel,
    output logic [width-1:0] out,
    output logic             carry
);

    logic [width-1:0] sum;
    logic             cout;
    logic [width-1:0] res_c;
    logic             carry_c;
    alu_op_e          op;

    assign op = alu_op_e'(sel);

    alu_ripple_adder #(.width(width)) u_adder (
        .a    (a),
        .b    (b),
        .sum  (sum),
        .cout (cout)
    );

    // Select adder or logic result; carry is only meaningful for ADD.
    always_comb begin
        res_c   = '0;
        carry_c = 1'b0;
        case (op)
            ALU_AND:  res_c = a & b;
            ALU_OR:   res_c = a | b;
            ALU_ADD: begin
                res_c   = sum;
                carry_c = cout;
            end
            ALU_NAND: res_c = ~(a & b);
        endcase
    end

    // Output register; reset clears result and carry without waiting for clk.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out   <= '0;
            carry <= 1'b0;
        end else begin
            out   <= res_c;
            carry <= carry_c;
        end
    end

endmodule

// File: tb/tb_alu_4bit.sv
// Directed + random bench for alu_4bit with an expected-result scoreboard.
module tb_alu_4bit;

    localparam int unsigned W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [W-1:0] a   = '0;
    logic [W-1:0] b   = '0;
    logic [1:0]   sel = 2'b00;
    logic [W-1:0] out;
    logic         carry;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [W-1:0] o;
        logic         c;
    } exp_t;

    exp_t sb[$];

    alu_4bit #(.width(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .a     (a),
        .b     (b),
        .sel   (sel),
        .out   (out),
        .carry (carry)
    );

    always #5 clk = ~clk;

    // Watchdog so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [W:0] obs, input logic [W:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed={carry,out}=%b expected=%b", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic [1:0] s);
        logic [W:0] r;
        case (s)
            2'b00:   r = {1'b0, x & y};
            2'b01:   r = {1'b0, x | y};
            2'b10:   r = {1'b0, x} + {1'b0, y};
            default: r = {1'b0, ~(x & y)};
        endcase
        return '{o: r[W-1:0], c: r[W]};
    endfunction

    task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic [1:0] s,
                         input logic [W-1:0] eo, input logic ec);
        @(negedge clk);
        a   = ia;
        b   = ib;
        sel = s;
        sb.push_back('{o: eo, c: ec});
    endtask

    task automatic collect(input string tag);
        exp_t e;
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s scoreboard empty observed=%b", tag, {carry, out});
        end else begin
            e = sb.pop_front();
            check(tag, {carry, out}, {e.c, e.o});
        end
    endtask

    task automatic step(input string tag, input logic [W-1:0] ia, input logic [W-1:0] ib,
                        input logic [1:0] s, input logic [W-1:0] eo, input logic ec);
        issue(ia, ib, s, eo, ec);
        collect(tag);
    endtask

    initial begin
        exp_t e;
        logic [W-1:0] ra, rb;
        logic [1:0]   rs;

        // Power-on reset
        #1 rst = 1'b1;
        #2 check("reset_init", {carry, out}, 5'b0_0000);
        @(negedge clk);
        rst = 1'b0;

        // AND
        step("and_0011_0111", 4'b0011, 4'b0111, 2'b00, 4'b0011, 1'b0);
        step("and_1011_0110", 4'b1011, 4'b0110, 2'b00, 4'b0010, 1'b0);
        step("and_1111_0100", 4'b1111, 4'b0100, 2'b00, 4'b0100, 1'b0);
        // OR
        step("or_0010_1111",  4'b0010, 4'b1111, 2'b01, 4'b1111, 1'b0);
        step("or_1011_0011",  4'b1011, 4'b0011, 2'b01, 4'b1011, 1'b0);
        step("or_0001_0101",  4'b0001, 4'b0101, 2'b01, 4'b0101, 1'b0);
        // ADD
        step("add_0011_0111", 4'b0011, 4'b0111, 2'b10, 4'b1010, 1'b0);
        step("add_0010_1111", 4'b0010, 4'b1111, 2'b10, 4'b0001, 1'b1);
        step("add_1011_0110", 4'b1011, 4'b0110, 2'b10, 4'b0001, 1'b1);
        step("add_1011_0011", 4'b1011, 4'b0011, 2'b10, 4'b1110, 1'b0);
        // NAND
        step("nand_1011_0110", 4'b1011, 4'b0110, 2'b11, 4'b1101, 1'b0);
        step("nand_1111_1111", 4'b1111, 4'b1111, 2'b11, 4'b0000, 1'b0);

        // Mid-stream asynchronous reset with ADD 1111+0100 on the inputs
        step("add_pre_reset", 4'b1111, 4'b0100, 2'b10, 4'b0011, 1'b1);
        #2 rst = 1'b1;
        #1 check("reset_async", {carry, out}, 5'b0_0000);
        sb.delete();
        @(posedge clk);
        #1 check("reset_hold", {carry, out}, 5'b0_0000);
        @(negedge clk);
        rst = 1'b0;
        sb.push_back('{o: 4'b0011, c: 1'b1});
        collect("reset_release");

        // Opcode switch latency: AND result persists until the next edge
        step("lat_and", 4'b0111, 4'b0011, 2'b00, 4'b0011, 1'b0);
        @(negedge clk);
        sel = 2'b10;
        #1 check("lat_sel_hold", {carry, out}, 5'b0_0011);
        sb.push_back('{o: 4'b1010, c: 1'b0});
        collect("lat_add");

        // Inputs toggled between edges never reach the outputs
        @(negedge clk);
        a = 4'b0001; b = 4'b0001; sel = 2'b01;
        #1 a = 4'b1111;
        #1 b = 4'b1010; sel = 2'b11;
        #1 check("toggle_hold", {carry, out}, 5'b0_1010);
        a = 4'b0100; b = 4'b0010; sel = 2'b01;
        sb.push_back('{o: 4'b0110, c: 1'b0});
        collect("toggle_final");

        // Random back-to-back operations against the reference model
        for (int i = 0; i < 24; i++) begin
            ra = W'($urandom_range(0, 15));
            rb = W'($urandom_range(0, 15));
            rs = 2'($urandom_range(0, 3));
            e  = model(ra, rb, rs);
            step($sformatf("rand_%0d", i), ra, rb, rs, e.o, e.c);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
